// File: rtl/regfile_op_sequencer_pkg.sv
// Shared opcode and FSM state definitions for the register-file operation sequencer.
// Imported by the sequencer top level and its ALU.
package regfile_op_sequencer_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_MOV = 3'b101,
      OP_LDI = 3'b110,
      OP_NOP = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_EXEC,
      ST_WRITE
   } state_e;

   function automatic logic op_writes(input op_e op);
      return op != OP_NOP;
   endfunction

endpackage

// File: rtl/regfile_op_sequencer_alu.sv
// Combinational ALU for the sequencer: (op, a, b, imm) -> result, modulo 2**DATA_W.
// NOP yields zero so the reported result of a NOP is well defined.
module regfile_op_sequencer_alu
   import regfile_op_sequencer_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  op_e               op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] result
);

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_MOV:  result = a;
         OP_LDI:  result = imm;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Command-driven initiator for a two-read/one-write register file.
// Each accepted command runs READ -> EXEC -> WRITE, one cycle each, then returns to IDLE.
module regfile_op_sequencer
   import regfile_op_sequencer_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic [ADDR_W-1:0] cmd_ra,
   input  logic [ADDR_W-1:0] cmd_rb,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic [ADDR_W-1:0] RA_addr,
   output logic [ADDR_W-1:0] RB_addr,
   input  logic [DATA_W-1:0] RA_data,
   input  logic [DATA_W-1:0] RB_data,
   output logic [ADDR_W-1:0] WR_addr,
   output logic [DATA_W-1:0] WR_data,
   output logic              WE,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_data
);

   state_e            state_q, state_d;
   op_e               op_q;
   logic [ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] alu_res;
   logic              accept;

   assign cmd_ready = (state_q == ST_IDLE);
   assign accept    = cmd_valid && cmd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_READ;
         ST_READ:  state_d = ST_EXEC;
         ST_EXEC:  state_d = ST_WRITE;
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   regfile_op_sequencer_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .imm    (imm_q),
      .result (alu_res)
   );

   // RA/RB addresses are loaded on accept so they are already valid throughout READ,
   // and they double as the latched ra/rb, holding their value until the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= OP_ADD;
         rd_q      <= '0;
         imm_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         RA_addr   <= '0;
         RB_addr   <= '0;
         WR_addr   <= '0;
         WR_data   <= '0;
         WE        <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q    <= op_e'(cmd_op);
                  rd_q    <= cmd_rd;
                  imm_q   <= cmd_imm;
                  RA_addr <= cmd_ra;
                  RB_addr <= cmd_rb;
               end
            end
            ST_READ: begin
               a_q <= RA_data;
               b_q <= RB_data;
            end
            ST_EXEC: begin
               WR_addr   <= rd_q;
               WR_data   <= alu_res;
               res_data  <= alu_res;
               WE        <= op_writes(op_q);
               res_valid <= 1'b1;
            end
            ST_WRITE: begin
               WE        <= 1'b0;
               res_valid <= 1'b0;
            end
            default: begin
               WE        <= 1'b0;
               res_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
